scoreboard_ctrl: RTL and testbench

- Register-hazard scheduler between issue_queue and issue in the dual-lane in-order pipeline (IS -> EX -> MEM -> CMT).
- Tracks, per architectural register, the youngest in-flight producer and the pipeline stage and lane that hold it.
- Decides each cycle which of the two queue-head instructions may issue, and drives the per-operand bypass select consumed by bypass.
- Counts hazard-stall cycles for performance debug.

---
 rtl/scoreboard_ctrl.sv | 78 +++++++
 tb/tb_scoreboard_ctrl.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/scoreboard_ctrl.sv
// scoreboard_ctrl: dual-lane register-hazard scheduler with bypass select; `define SCOREBOARD_CMT_BYPASS_EN forwards CMT-stage results
module scoreboard_ctrl #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             req_valid,
  input  logic [1:0]             req_wena,
  input  logic [1:0][ADDR_W-1:0] req_waddr,
  input  logic [1:0]             req_is_load,
  input  logic [3:0][ADDR_W-1:0] src_addr,
  input  logic                   flush,
  output logic [1:0]             issue_fire,
  output logic [3:0][2:0]        src_sel,
  output logic [3:0]             src_ready,
  output logic [ADDR_W:0]        inflight_cnt,
  output logic [CNT_W-1:0]       stall_cnt
);
`ifdef SCOREBOARD_CMT_BYPASS_EN
  localparam bit CMT_BYP = 1'b1;
`else
  localparam bit CMT_BYP = 1'b0;
`endif
  typedef enum logic [1:0] {NONE, EX, MEM, CMT} stage_t;
  stage_t stage_q [NUM_REGS];
  stage_t stage_d [NUM_REGS];
  logic [NUM_REGS-1:0] lane_q, lane_d, load_q, load_d;
  logic [ADDR_W:0] cnt_d;
  logic raw;
  for (genvar i = 0; i < 4; i++) begin : g_op
    stage_t st;
    logic ln, ld;
    assign st = src_addr[i] != '0 ? stage_q[src_addr[i]] : NONE;
    assign ln = lane_q[src_addr[i]];
    assign ld = load_q[src_addr[i]];
    assign src_ready[i] = !(st == EX && ld) && !(st == CMT && !CMT_BYP);
    assign src_sel[i] = st == EX && !ld ? 3'd1 + 3'(ln) :
                        st == MEM ? 3'd3 + 3'(ln) :
                        st == CMT && CMT_BYP ? 3'd5 + 3'(ln) : 3'd0;
  end
  // lane1 may not read what the older lane0 of the same pair is about to write
  assign raw = req_wena[0] && req_waddr[0] != '0 &&
               (src_addr[2] == req_waddr[0] || src_addr[3] == req_waddr[0]);
  assign issue_fire[0] = req_valid[0] && src_ready[0] && src_ready[1];
  assign issue_fire[1] = issue_fire[0] && req_valid[1] && src_ready[2] && src_ready[3] && !raw;
  // lane1 is applied after lane0 so the younger writer wins on a shared destination
  always_comb begin
    cnt_d = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      stage_d[r] = flush || stage_q[r] == CMT || stage_q[r] == NONE ? NONE : stage_t'(stage_q[r] + 2'd1);
      lane_d[r] = lane_q[r];
      load_d[r] = load_q[r];
      for (int l = 0; l < 2; l++)
        if (!flush && issue_fire[l] && req_wena[l] && req_waddr[l] != '0 && req_waddr[l] == ADDR_W'(r)) begin
          stage_d[r] = EX;
          lane_d[r] = l[0];
          load_d[r] = req_is_load[l];
        end
      cnt_d = cnt_d + (ADDR_W+1)'(stage_d[r] != NONE);
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) stage_q[r] <= NONE;
      lane_q <= '0;
      load_q <= '0;
      inflight_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      stage_q <= stage_d;
      lane_q <= lane_d;
      load_q <= load_d;
      inflight_cnt <= cnt_d;
      if (req_valid[0] && !issue_fire[0] && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    end
endmodule

// File: tb/tb_scoreboard_ctrl.sv
// tb_scoreboard_ctrl: directed self-checking bench for scoreboard_ctrl
module tb_scoreboard_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  logic [1:0] req_valid = '0, req_wena = '0, req_is_load = '0, issue_fire;
  logic [1:0][4:0] req_waddr = '0;
  logic [3:0][4:0] src_addr = '0;
  logic [3:0][2:0] src_sel;
  logic [3:0] src_ready;
  logic [5:0] inflight_cnt;
  logic [31:0] stall_cnt;
  int passed = 0, total = 0;
  scoreboard_ctrl dut (.clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_wena(req_wena),
    .req_waddr(req_waddr), .req_is_load(req_is_load), .src_addr(src_addr), .flush(flush),
    .issue_fire(issue_fire), .src_sel(src_sel), .src_ready(src_ready),
    .inflight_cnt(inflight_cnt), .stall_cnt(stall_cnt));
  always #5 clk = ~clk;
`ifdef SCOREBOARD_CMT_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic drive(input logic [1:0] v, input logic [1:0] w, input logic [1:0] ld,
                       input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] s0,
                       input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] s3);
    req_valid = v; req_wena = w; req_is_load = ld;
    req_waddr[0] = a0; req_waddr[1] = a1;
    src_addr[0] = s0; src_addr[1] = s1; src_addr[2] = s2; src_addr[3] = s3;
    #1;
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    #1;
    chk("reset_inflight", 32'(inflight_cnt), 0);
    chk("reset_stall", stall_cnt, 0);
    chk("reset_ready", 32'(src_ready), 32'hf);
    #6 rst_n = 1'b1;
    drive(2'b11, 2'b11, 2'b00, 5, 6, 1, 2, 3, 4);
    chk("indep_fire", 32'(issue_fire), 32'b11);
    chk("indep_sel", 32'(src_sel), 0);
    chk("indep_inflight_pre", 32'(inflight_cnt), 0);
    tick;
    chk("indep_inflight_post", 32'(inflight_cnt), 2);
    drive(2'b01, 2'b00, 2'b00, 0, 0, 5, 6, 0, 0);
    chk("ex_sel_l0", 32'(src_sel[0]), 1);
    chk("ex_sel_l1", 32'(src_sel[1]), 2);
    chk("ex_fire", 32'(issue_fire), 32'b01);
    tick;
    chk("mem_sel_l0", 32'(src_sel[0]), 3);
    chk("mem_sel_l1", 32'(src_sel[1]), 4);
    tick;
    chk("cmt_sel_l0", 32'(src_sel[0]), BYP ? 5 : 0);
    chk("cmt_sel_l1", 32'(src_sel[1]), BYP ? 6 : 0);
    chk("cmt_ready", 32'(src_ready[1:0]), BYP ? 32'b11 : 32'b00);
    chk("cmt_fire", 32'(issue_fire), BYP ? 32'b01 : 32'b00);
    tick;
    chk("none_sel", 32'(src_sel), 0);
    chk("none_fire", 32'(issue_fire), 32'b01);
    chk("drained_inflight", 32'(inflight_cnt), 0);
    chk("stall_after_cmt", stall_cnt, BYP ? 0 : 1);
    drive(2'b11, 2'b10, 2'b10, 0, 7, 1, 2, 3, 4);
    chk("load_issue_fire", 32'(issue_fire), 32'b11);
    tick;
    drive(2'b01, 2'b00, 2'b00, 0, 0, 7, 0, 0, 0);
    chk("load_use_ready", 32'(src_ready[0]), 0);
    chk("load_use_sel", 32'(src_sel[0]), 0);
    chk("load_use_fire", 32'(issue_fire), 32'b00);
    tick;
    chk("load_stall_cnt", stall_cnt, BYP ? 1 : 2);
    chk("load_mem_sel", 32'(src_sel[0]), 4);
    chk("load_mem_fire", 32'(issue_fire), 32'b01);
    tick;
    drive(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    tick;
    chk("load_drained", 32'(inflight_cnt), 0);
    drive(2'b11, 2'b01, 2'b00, 8, 0, 1, 2, 8, 3);
    chk("intra_raw_fire", 32'(issue_fire), 32'b01);
    tick;
    drive(2'b01, 2'b00, 2'b00, 0, 0, 8, 3, 0, 0);
    chk("intra_next_sel", 32'(src_sel[0]), 1);
    chk("intra_next_fire", 32'(issue_fire), 32'b01);
    tick;
    drive(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    tick;
    tick;
    chk("intra_drained", 32'(inflight_cnt), 0);
    drive(2'b11, 2'b11, 2'b00, 9, 9, 1, 2, 3, 4);
    chk("waw_fire", 32'(issue_fire), 32'b11);
    tick;
    chk("waw_inflight", 32'(inflight_cnt), 1);
    drive(2'b01, 2'b00, 2'b00, 0, 0, 9, 0, 0, 0);
    chk("waw_ex_sel", 32'(src_sel[0]), 2);
    tick;
    chk("waw_mem_sel", 32'(src_sel[0]), 4);
    tick;
    chk("waw_cmt_sel", 32'(src_sel[0]), BYP ? 6 : 0);
    chk("waw_cmt_ready", 32'(src_ready[0]), BYP ? 1 : 0);
    tick;
    chk("waw_stall_cnt", stall_cnt, BYP ? 1 : 3);
    drive(2'b01, 2'b01, 2'b00, 0, 0, 1, 2, 0, 0);
    chk("r0_write_fire", 32'(issue_fire), 32'b01);
    tick;
    chk("r0_inflight", 32'(inflight_cnt), 0);
    drive(2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    chk("r0_read_sel", 32'(src_sel[0]), 0);
    chk("r0_read_ready", 32'(src_ready[0]), 1);
    tick;
    drive(2'b11, 2'b11, 2'b00, 10, 11, 1, 2, 3, 4);
    tick;
    drive(2'b01, 2'b01, 2'b00, 12, 0, 1, 2, 0, 0);
    tick;
    chk("pre_flush_inflight", 32'(inflight_cnt), 3);
    flush = 1'b1;
    drive(2'b01, 2'b01, 2'b00, 13, 0, 1, 2, 0, 0);
    chk("flush_fire_comb", 32'(issue_fire), 32'b01);
    tick;
    flush = 1'b0;
    drive(2'b11, 2'b00, 2'b00, 0, 0, 10, 11, 12, 13);
    chk("flush_inflight", 32'(inflight_cnt), 0);
    chk("flush_sel", 32'(src_sel), 0);
    chk("flush_ready", 32'(src_ready), 32'hf);
    chk("flush_stall_kept", stall_cnt, BYP ? 1 : 3);
    drive(2'b01, 2'b01, 2'b00, 14, 0, 1, 2, 0, 0);
    tick;
    chk("pre_reset_inflight", 32'(inflight_cnt), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_inflight", 32'(inflight_cnt), 0);
    chk("async_stall", stall_cnt, 0);
    chk("async_sel", 32'(src_sel), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
